parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAP, default 15, maximum occupancy count.
REQ-002 Parameter CNT_W, default 4, width of the occupancy count; CAP SHALL satisfy CAP <= 2**CNT_W - 1.
REQ-003 Parameter TIMEOUT, default 64, number of cycles with a, b unchanged in a non-IDLE state before abort (used only with GATE_TIMEOUT_EN).
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a  input  1  outer beam sensor; 1 = blocked; synchronous to clk.
REQ-007 b  input  1  inner beam sensor; 1 = blocked; synchronous to clk.
REQ-008 inc  output  1  one-cycle pulse: entry accepted.
REQ-009 dec  output  1  one-cycle pulse: exit accepted.
REQ-010 count  output  CNT_W  current occupancy.
REQ-011 full  output  1  high when count == CAP.
REQ-012 empty  output  1  high when count == 0.
REQ-013 reject  output  1  one-cycle pulse: entry completed while full, or exit completed while empty.
REQ-014 err  output  1  one-cycle pulse: illegal sensor transition, or timeout.
REQ-015 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and ERR; {a,b} is sampled every clock.
REQ-017 IDLE SHALL respond to {a,b} as follows:
- 10 -> EN1.
- 01 -> EX1.
- 00 -> stay.
- 11 -> ERR with an err pulse.
REQ-018 The entry path SHALL follow EN1 (10) -> EN2 (11) -> EN3 (01) -> IDLE (00); the exit path SHALL follow EX1 (01) -> EX2 (11) -> EX3 (10) -> IDLE (00).
REQ-019 Reversal SHALL be legal and SHALL produce no pulse:
- EN3 on 11 -> EN2; EN2 on 10 -> EN1; EN1 on 00 -> IDLE.
- The exit path mirrors this.
REQ-020 A pattern equal to the current state's pattern SHALL hold the state.
REQ-021 Any other pattern SHALL go to ERR and pulse err for one cycle.
REQ-022 ERR SHALL stay in ERR until {a,b} == 00, then go to IDLE; no inc, dec or reject is generated while in ERR.
REQ-023 EN3 on 00 (entry completion) SHALL be handled as follows:
- If count < CAP: in the next cycle inc = 1 and count = count + 1, both visible together (registered, latency 1).
- Otherwise: reject = 1 for one cycle and count is held.
REQ-024 EX3 on 00 (exit completion) SHALL be handled as follows:
- If count > 0: dec = 1 and count = count - 1 in the next cycle.
- Otherwise: reject = 1 and count is held.
REQ-025 inc and dec SHALL never be high in the same cycle; count SHALL never wrap past CAP or below 0.
REQ-026 full, empty and busy SHALL be registered and consistent with count and state in the same cycle.
REQ-027 busy SHALL be high in ERR.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL enter IDLE and force count = 0, and all other registered outputs to the following values:
- empty = 1.
- full = 0.
- inc = 0, dec = 0, reject = 0, err = 0.
- busy = 0.
REQ-029 rst SHALL take priority over any sequence in progress; a partial sequence SHALL be discarded with no pulse.
REQ-030 After rst deasserts, the first sampled {a,b} SHALL be evaluated from IDLE.

Configuration
REQ-031 Macro GATE_TIMEOUT_EN SHALL control the inactivity timeout.
- Defined: a counter of width clog2(TIMEOUT + 1) clears on entry to any non-IDLE, non-ERR state and on every {a,b} change. When it reaches TIMEOUT, the FSM goes to ERR and pulses err once.
- Undefined: no counter is compiled in, and non-IDLE states hold indefinitely.

Verification
REQ-032 Reset, then 5 entry sequences (00,10,11,01,00, each pattern held 1 cycle) -> 5 inc pulses, each 1 cycle after its final 00 sample; count = 5, empty = 0.
REQ-033 From count = 5, 4 exit sequences (01,11,10,00) -> 4 dec pulses; count = 1.
REQ-034 From count = 6, 15 entry sequences (CAP = 15) -> 9 inc pulses, then 6 reject pulses; count = 15 and full = 1 throughout the rejects.
REQ-035 Sequence 10,11,10,00 (reversal), then IDLE 11 -> no inc; err pulses once on 11; busy stays high until 00, then IDLE.
REQ-036 rst asserted while in EN3 -> the next cycle is IDLE with count = 0 and no inc; with GATE_TIMEOUT_EN, holding 10 for TIMEOUT cycles -> 1 err pulse and ERR state.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_ctrl
//  Description : Two-beam parking gate direction decoder with occupancy count.
//                Optional inactivity abort enabled by macro GATE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
    parameter int CAP     = 15,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             inc,
    output logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_EN1  = 3'd1;
    localparam logic [2:0] c_EN2  = 3'd2;
    localparam logic [2:0] c_EN3  = 3'd3;
    localparam logic [2:0] c_EX1  = 3'd4;
    localparam logic [2:0] c_EX2  = 3'd5;
    localparam logic [2:0] c_EX3  = 3'd6;
    localparam logic [2:0] c_ERR  = 3'd7;

    localparam logic [CNT_W-1:0] c_CAP  = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [1:0]       w_ab;
    logic             w_err;
    logic             w_fin_en;
    logic             w_fin_ex;
    logic             w_inc;
    logic             w_dec;
    logic             w_rej;
    logic             w_active;
    logic             w_tmo_hit;
    logic [CNT_W-1:0] w_count_nxt;

    logic [CNT_W-1:0] r_count;
    logic             r_inc;
    logic             r_dec;
    logic             r_rej;
    logic             r_err;
    logic             r_full;
    logic             r_empty;
    logic             r_busy;

    assign w_ab     = {a, b};
    assign w_active = (r_state != c_IDLE) && (r_state != c_ERR);

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned c_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO = c_TMO_W'(TIMEOUT);

    logic [c_TMO_W-1:0] r_tmo;

    // In an active state the pattern is unchanged exactly when the state holds,
    // so a state change doubles as the "sensor changed" clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (!w_active || (w_next != r_state)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = w_active && (r_tmo == c_TMO);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_err    = 1'b0;
        w_fin_en = 1'b0;
        w_fin_ex = 1'b0;
        case (r_state)
            c_IDLE: begin
                case (w_ab)
                    2'b10:   w_next = c_EN1;
                    2'b01:   w_next = c_EX1;
                    2'b11:   begin w_next = c_ERR; w_err = 1'b1; end
                    default: w_next = c_IDLE;
                endcase
            end
            c_EN1: begin
                case (w_ab)
                    2'b10:   w_next = c_EN1;
                    2'b11:   w_next = c_EN2;
                    2'b00:   w_next = c_IDLE;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_EN2: begin
                case (w_ab)
                    2'b11:   w_next = c_EN2;
                    2'b01:   w_next = c_EN3;
                    2'b10:   w_next = c_EN1;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_EN3: begin
                case (w_ab)
                    2'b01:   w_next = c_EN3;
                    2'b00:   begin w_next = c_IDLE; w_fin_en = 1'b1; end
                    2'b11:   w_next = c_EN2;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_EX1: begin
                case (w_ab)
                    2'b01:   w_next = c_EX1;
                    2'b11:   w_next = c_EX2;
                    2'b00:   w_next = c_IDLE;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_EX2: begin
                case (w_ab)
                    2'b11:   w_next = c_EX2;
                    2'b10:   w_next = c_EX3;
                    2'b01:   w_next = c_EX1;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_EX3: begin
                case (w_ab)
                    2'b10:   w_next = c_EX3;
                    2'b00:   begin w_next = c_IDLE; w_fin_ex = 1'b1; end
                    2'b11:   w_next = c_EX2;
                    default: begin w_next = c_ERR; w_err = 1'b1; end
                endcase
            end
            c_ERR: begin
                if (w_ab == 2'b00) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase

        // Abort only applies while the sequence is parked on its own pattern.
        if (w_tmo_hit && (w_next == r_state)) begin
            w_next = c_ERR;
            w_err  = 1'b1;
        end
    end

    assign w_inc = w_fin_en && (r_count < c_CAP);
    assign w_dec = w_fin_ex && (r_count != c_ZERO);
    assign w_rej = (w_fin_en && (r_count >= c_CAP)) || (w_fin_ex && (r_count == c_ZERO));

    always_comb begin
        w_count_nxt = r_count;
        if (w_inc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_dec) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_rej   <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_nxt;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
            r_rej   <= w_rej;
            r_err   <= w_err;
            r_full  <= (w_count_nxt == c_CAP);
            r_empty <= (w_count_nxt == c_ZERO);
            r_busy  <= (w_next != c_IDLE);
        end
    end

    assign inc    = r_inc;
    assign dec    = r_dec;
    assign count  = r_count;
    assign full   = r_full;
    assign empty  = r_empty;
    assign reject = r_rej;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_ctrl
//  Description : Self-checking bench for parking_gate_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;

    localparam int CAP     = 15;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a   = 1'b0;
    logic             b   = 1'b0;
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             reject;
    logic             err;
    logic             busy;

    parking_gate_ctrl #(.CAP(CAP), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .inc(inc), .dec(dec), .count(count), .full(full), .empty(empty),
        .reject(reject), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output bundle: {inc,dec,reject,err,busy,full,empty,count[3:0]}
    typedef struct {
        logic        r;
        logic [1:0]  ab;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          m_cnt = 0;
    int          n_inc = 0;
    int          n_rej = 0;

    wire [10:0] act = {inc, dec, reject, err, busy, full, empty, count};

    function automatic logic [10:0] ex(input logic i, input logic d, input logic rj,
                                       input logic e, input logic bz, input int c);
        logic [3:0] c4;
        c4 = c[3:0];
        return {i, d, rj, e, bz, (c == CAP), (c == 0), c4};
    endfunction

    task automatic add(input logic r, input logic [1:0] ab, input logic [10:0] e);
        vec_t v;
        v.r = r; v.ab = ab; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic ok, input int got, input int want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    task automatic step(input logic r, input logic [1:0] ab, input logic [10:0] e, input string nm);
        logic [10:0] want;
        @(negedge clk);
        rst = r;
        {a, b} = ab;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        n_inc += int'(act[10]);
        n_rej += int'(act[8]);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b want %b (inc,dec,rej,err,busy,full,empty,count)", nm, act, want);
    endtask

    task automatic entry(input string nm);
        step(1'b0, 2'b10, ex(0, 0, 0, 0, 1, m_cnt), nm);
        step(1'b0, 2'b11, ex(0, 0, 0, 0, 1, m_cnt), nm);
        step(1'b0, 2'b01, ex(0, 0, 0, 0, 1, m_cnt), nm);
        if (m_cnt < CAP) begin
            m_cnt++;
            step(1'b0, 2'b00, ex(1, 0, 0, 0, 0, m_cnt), nm);
        end else begin
            step(1'b0, 2'b00, ex(0, 0, 1, 0, 0, m_cnt), nm);
        end
    endtask

    task automatic exit_seq(input string nm);
        step(1'b0, 2'b01, ex(0, 0, 0, 0, 1, m_cnt), nm);
        step(1'b0, 2'b11, ex(0, 0, 0, 0, 1, m_cnt), nm);
        step(1'b0, 2'b10, ex(0, 0, 0, 0, 1, m_cnt), nm);
        if (m_cnt > 0) begin
            m_cnt--;
            step(1'b0, 2'b00, ex(0, 1, 0, 0, 0, m_cnt), nm);
        end else begin
            step(1'b0, 2'b00, ex(0, 0, 1, 0, 0, m_cnt), nm);
        end
    endtask

    initial begin
        logic [10:0] rs, i0, i1, b0, b1, ep;
        rs = ex(0, 0, 0, 0, 0, 0);
        i0 = ex(0, 0, 0, 0, 0, 0);
        i1 = ex(0, 0, 0, 0, 0, 1);
        b0 = ex(0, 0, 0, 0, 1, 0);
        b1 = ex(0, 0, 0, 0, 1, 1);
        ep = ex(0, 0, 0, 1, 1, 0);

        // reset, reset wins over an active pattern
        add(1, 2'b00, rs); add(1, 2'b10, rs); add(0, 2'b00, i0);
        // single entry, inc visible one cycle after the closing 00
        add(0, 2'b10, b0); add(0, 2'b11, b0); add(0, 2'b01, b0);
        add(0, 2'b00, ex(1, 0, 0, 0, 0, 1)); add(0, 2'b00, i1);
        // single exit
        add(0, 2'b01, b1); add(0, 2'b11, b1); add(0, 2'b10, b1);
        add(0, 2'b00, ex(0, 1, 0, 0, 0, 0));
        // exit while empty rejects
        add(0, 2'b01, b0); add(0, 2'b11, b0); add(0, 2'b10, b0);
        add(0, 2'b00, ex(0, 0, 1, 0, 0, 0)); add(0, 2'b00, i0);
        // entry reversal then illegal 11 from IDLE; ERR holds until 00
        add(0, 2'b10, b0); add(0, 2'b11, b0); add(0, 2'b10, b0); add(0, 2'b00, i0);
        add(0, 2'b11, ep); add(0, 2'b11, b0); add(0, 2'b01, b0); add(0, 2'b00, i0);
        // illegal jump mid-sequence
        add(0, 2'b10, b0); add(0, 2'b01, ep); add(0, 2'b00, i0);
        // EN3 -> EN2 -> EN3 reversal still completes
        add(0, 2'b10, b0); add(0, 2'b11, b0); add(0, 2'b01, b0); add(0, 2'b11, b0);
        add(0, 2'b01, b0); add(0, 2'b00, ex(1, 0, 0, 0, 0, 1));
        // held patterns, then reset while in EN3 discards the sequence
        add(0, 2'b10, b1); add(0, 2'b10, b1); add(0, 2'b11, b1); add(0, 2'b11, b1);
        add(0, 2'b01, b1); add(0, 2'b01, b1); add(1, 2'b00, rs);
        add(0, 2'b10, b0); add(0, 2'b00, i0);
        // exit reversal
        add(0, 2'b01, b0); add(0, 2'b11, b0); add(0, 2'b01, b0); add(0, 2'b00, i0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].ab, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // five entries, four exits
        step(1'b1, 2'b00, rs, "reset2");
        m_cnt = 0;
        for (int i = 0; i < 5; i++) entry("entry5");
        check("count_after_5", count == 4'd5 && !empty, int'(count), 5);
        for (int i = 0; i < 4; i++) exit_seq("exit4");
        check("count_after_4x", count == 4'd1, int'(count), 1);
        for (int i = 0; i < 5; i++) entry("fill_to_6");

        // fill past capacity
        n_inc = 0;
        n_rej = 0;
        for (int i = 0; i < 15; i++) entry("fill_cap");
        check("inc_pulses", n_inc == 9, n_inc, 9);
        check("rej_pulses", n_rej == 6, n_rej, 6);
        check("full_at_cap", full == 1'b1 && count == 4'd15, int'(count), 15);
        exit_seq("exit_from_full");

`ifdef GATE_TIMEOUT_EN
        begin
            int n_err;
            n_err = 0;
            step(1'b0, 2'b10, ex(0, 0, 0, 0, 1, m_cnt), "tmo_enter");
            for (int k = 0; k < TIMEOUT + 8; k++) begin
                @(negedge clk);
                @(posedge clk);
                #1;
                n_err += int'(err);
            end
            check("tmo_err_pulses", n_err == 1, n_err, 1);
            check("tmo_busy_in_err", busy == 1'b1, int'(busy), 1);
            step(1'b0, 2'b00, ex(0, 0, 0, 0, 0, m_cnt), "tmo_release");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
